// File: rtl/pc_predict_unit.sv
// Fetch PC selection and next-PC prediction with F_predPC register and optional
// speculative return address stack, enabled by defining PC_PREDICT_RAS_EN.
module pc_predict_unit #(
  parameter int                ADDR_W    = 64,
  parameter int                RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  localparam int               PTR_W     = $clog2(RAS_DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              F_stall_i,
  input  logic [3:0]        f_icode_i,
  input  logic [ADDR_W-1:0] f_valC_i,
  input  logic [ADDR_W-1:0] f_valP_i,
  input  logic [3:0]        M_icode_i,
  input  logic              M_Cnd_i,
  input  logic [ADDR_W-1:0] M_valA_i,
  input  logic [PTR_W-1:0]  M_ras_ptr_i,
  input  logic [3:0]        W_icode_i,
  input  logic [ADDR_W-1:0] W_valM_i,
  input  logic [ADDR_W-1:0] W_predPC_i,
  input  logic [PTR_W-1:0]  W_ras_ptr_i,
  output logic [ADDR_W-1:0] f_pc_o,
  output logic [ADDR_W-1:0] F_predPC_o,
  output logic [PTR_W-1:0]  f_ras_ptr_o,
  output logic              f_redirect_o
);

  localparam logic [3:0] IJXX  = 4'h7;
  localparam logic [3:0] ICALL = 4'h8;
  localparam logic [3:0] IRET  = 4'h9;

  logic              w_fix;
  logic              m_fix;
  logic              upd;
  logic [ADDR_W-1:0] predpc_q;
  logic [ADDR_W-1:0] predpc_d;

`ifdef PC_PREDICT_RAS_EN
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [PTR_W-1:0]  ptr_q;
  logic [PTR_W-1:0]  ptr_d;
  logic [PTR_W-1:0]  base;
  logic              push;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

  // A correctly predicted ret needs no repair.
  assign w_fix = (W_icode_i == IRET) && (W_valM_i != W_predPC_i);
`else
  logic unused_ras;

  // Without a RAS every ret is repaired from W.
  assign w_fix      = (W_icode_i == IRET);
  assign unused_ras = ^{M_ras_ptr_i, W_ras_ptr_i, W_predPC_i};
`endif

  assign m_fix        = (M_icode_i == IJXX) && !M_Cnd_i;
  assign f_redirect_o = w_fix | m_fix;
  assign F_predPC_o   = predpc_q;
  // A redirect overrides a stall so a repair is never dropped.
  assign upd          = !F_stall_i || f_redirect_o;

  always_comb begin
    f_pc_o   = predpc_q;
    predpc_d = f_valP_i;
    if (w_fix) begin
      f_pc_o = W_valM_i;
    end else if (m_fix) begin
      f_pc_o = M_valA_i;
    end
`ifdef PC_PREDICT_RAS_EN
    base = ptr_q;
    if (w_fix) begin
      base = W_ras_ptr_i;
    end else if (m_fix) begin
      base = M_ras_ptr_i;
    end
    ptr_d = base;
    push  = 1'b0;
`endif
    case (f_icode_i)
      ICALL: begin
        predpc_d = f_valC_i;
`ifdef PC_PREDICT_RAS_EN
        push  = 1'b1;
        ptr_d = base + PTR_ONE;
`endif
      end
      IJXX: predpc_d = f_valC_i;
`ifdef PC_PREDICT_RAS_EN
      IRET: begin
        predpc_d = ras_q[base - PTR_ONE];
        ptr_d    = base - PTR_ONE;
      end
`endif
      default: ;
    endcase
  end

`ifdef PC_PREDICT_RAS_EN
  assign f_ras_ptr_o = ptr_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      predpc_q <= RESET_PC;
      ptr_q    <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= '0;
      end
    end else if (upd) begin
      predpc_q <= predpc_d;
      ptr_q    <= ptr_d;
      // Pushing at a full stack silently overwrites the oldest entry.
      if (push) begin
        ras_q[base] <= f_valP_i;
      end
    end
  end
`else
  assign f_ras_ptr_o = '0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      predpc_q <= RESET_PC;
    end else if (upd) begin
      predpc_q <= predpc_d;
    end
  end
`endif

endmodule

// File: tb/tb_pc_predict_unit.sv
// Scoreboard bench for pc_predict_unit; expectations cover both RAS-enabled and
// RAS-disabled builds (PC_PREDICT_RAS_EN).
module tb_pc_predict_unit;

  localparam int ADDR_W = 64;
  localparam int DEPTH  = 4;
  localparam int PW     = 2;
`ifdef PC_PREDICT_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  localparam logic [3:0] INOP = 4'h1, IJXX = 4'h7, ICALL = 4'h8, IRET = 4'h9;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              F_stall;
  logic [3:0]        f_icode;
  logic [ADDR_W-1:0] f_valC, f_valP;
  logic [3:0]        M_icode;
  logic              M_Cnd;
  logic [ADDR_W-1:0] M_valA;
  logic [PW-1:0]     M_ras_ptr;
  logic [3:0]        W_icode;
  logic [ADDR_W-1:0] W_valM, W_predPC;
  logic [PW-1:0]     W_ras_ptr;
  logic [ADDR_W-1:0] f_pc, F_predPC;
  logic [PW-1:0]     f_ras_ptr;
  logic              f_redirect;

  pc_predict_unit #(.ADDR_W(ADDR_W), .RAS_DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .F_stall_i(F_stall),
    .f_icode_i(f_icode), .f_valC_i(f_valC), .f_valP_i(f_valP),
    .M_icode_i(M_icode), .M_Cnd_i(M_Cnd), .M_valA_i(M_valA), .M_ras_ptr_i(M_ras_ptr),
    .W_icode_i(W_icode), .W_valM_i(W_valM), .W_predPC_i(W_predPC), .W_ras_ptr_i(W_ras_ptr),
    .f_pc_o(f_pc), .F_predPC_o(F_predPC), .f_ras_ptr_o(f_ras_ptr), .f_redirect_o(f_redirect)
  );

  always #5 clk = ~clk;

  typedef struct {
    string             name;
    logic [ADDR_W-1:0] pred;
    logic [ADDR_W-1:0] pc;
    logic              redir;
    logic [PW-1:0]     ptr;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Staged M/W values, applied by the next step and then returned to idle.
  logic              s_rst_n = 1'b0;
  logic [3:0]        s_M_icode = INOP, s_W_icode = INOP;
  logic              s_M_Cnd = 1'b0;
  logic [ADDR_W-1:0] s_M_valA = '0, s_W_valM = '0, s_W_predPC = '0;
  logic [PW-1:0]     s_M_ptr = '0, s_W_ptr = '0;

  task automatic chk(input string nm, input string fld, input logic [ADDR_W-1:0] act,
                     input logic [ADDR_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
    end
  endtask

  task automatic step(input string nm, input logic [3:0] ic, input logic [ADDR_W-1:0] vc,
                      input logic [ADDR_W-1:0] vp, input logic stall,
                      input logic [ADDR_W-1:0] e_pred, input logic [ADDR_W-1:0] e_pc,
                      input logic e_redir, input logic [PW-1:0] e_ptr);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n     = s_rst_n;
    F_stall   = stall;
    f_icode   = ic;
    f_valC    = vc;
    f_valP    = vp;
    M_icode   = s_M_icode;  M_Cnd  = s_M_Cnd;  M_valA   = s_M_valA;   M_ras_ptr = s_M_ptr;
    W_icode   = s_W_icode;  W_valM = s_W_valM; W_predPC = s_W_predPC; W_ras_ptr = s_W_ptr;
    s_M_icode = INOP; s_M_Cnd = 1'b0; s_M_valA = '0; s_M_ptr = '0;
    s_W_icode = INOP; s_W_valM = '0; s_W_predPC = '0; s_W_ptr = '0;
    e.name = nm; e.pred = e_pred; e.pc = e_pc; e.redir = e_redir; e.ptr = e_ptr;
    q.push_back(e);
  endtask

  // Monitor: outputs are stable mid-cycle, compare against queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        chk(e.name, "F_predPC", F_predPC, e.pred);
        chk(e.name, "f_pc", f_pc, e.pc);
        chk(e.name, "redirect", {63'd0, f_redirect}, {63'd0, e.redir});
        chk(e.name, "ras_ptr", {62'd0, f_ras_ptr}, {62'd0, e.ptr});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; F_stall = 1'b0; f_icode = INOP; f_valC = '0; f_valP = 64'h1;
    M_icode = INOP; M_Cnd = 1'b0; M_valA = '0; M_ras_ptr = '0;
    W_icode = INOP; W_valM = '0; W_predPC = '0; W_ras_ptr = '0;

    step("rst",   INOP, 0, 64'h1, 0, 64'h0, 64'h0, 0, 0);
    s_rst_n = 1'b1;
    step("nop0",  INOP, 0, 64'h1, 0, 64'h0, 64'h0, 0, 0);
    step("nop1",  INOP, 0, 64'h10, 0, 64'h1, 64'h1, 0, 0);
    step("call",  ICALL, 64'h100, 64'h19, 0, 64'h10, 64'h10, 0, RAS ? 2'd1 : 2'd0);
    step("retf",  IRET, 0, 64'h101, 0, 64'h100, 64'h100, 0, 0);
    s_W_icode = IRET; s_W_valM = 64'h19; s_W_predPC = 64'h19; s_W_ptr = 0;
    step("retw",  INOP, 0, 64'h1A, 0, RAS ? 64'h19 : 64'h101, 64'h19, !RAS, 0);
    step("call2", ICALL, 64'h300, 64'h1F, 0, 64'h1A, 64'h1A, 0, RAS ? 2'd1 : 2'd0);
    step("call3", ICALL, 64'h400, 64'h305, 0, 64'h300, 64'h300, 0, RAS ? 2'd2 : 2'd0);
    step("wpcal", ICALL, 64'h500, 64'h405, 0, 64'h400, 64'h400, 0, RAS ? 2'd3 : 2'd0);
    s_M_icode = IJXX; s_M_Cnd = 1'b0; s_M_valA = 64'h40; s_M_ptr = 2;
    step("mfix",  INOP, 0, 64'h41, 1, 64'h500, 64'h40, 1, RAS ? 2'd2 : 2'd0);
    s_M_icode = IJXX; s_M_Cnd = 1'b1; s_M_valA = 64'h99; s_M_ptr = 0;
    step("mtake", INOP, 0, 64'h42, 0, 64'h41, 64'h41, 0, RAS ? 2'd2 : 2'd0);
    s_W_icode = IRET; s_W_valM = 64'h200; s_W_predPC = 64'h19; s_W_ptr = 1;
    s_M_icode = IJXX; s_M_Cnd = 1'b0; s_M_valA = 64'h40; s_M_ptr = 3;
    step("both",  INOP, 0, 64'h201, 0, 64'h42, 64'h200, 1, RAS ? 2'd1 : 2'd0);
    step("ret2",  IRET, 0, 64'h202, 0, 64'h201, 64'h201, 0, 0);
    step("stall", ICALL, 64'h600, 64'h25, 1, RAS ? 64'h1F : 64'h202,
         RAS ? 64'h1F : 64'h202, 0, RAS ? 2'd1 : 2'd0);
    step("callg", ICALL, 64'h600, 64'h25, 0, RAS ? 64'h1F : 64'h202,
         RAS ? 64'h1F : 64'h202, 0, RAS ? 2'd1 : 2'd0);
    step("ret3",  IRET, 0, 64'h601, 0, 64'h600, 64'h600, 0, 0);
    step("nop2",  INOP, 0, 64'h26, 0, RAS ? 64'h25 : 64'h601, RAS ? 64'h25 : 64'h601, 0, 0);
`ifdef PC_PREDICT_RAS_EN
    step("ovA",   ICALL, 64'h700, 64'hA, 0, 64'h26, 64'h26, 0, 2'd1);
    step("ovB",   ICALL, 64'h700, 64'hB, 0, 64'h700, 64'h700, 0, 2'd2);
    step("ovC",   ICALL, 64'h700, 64'hC, 0, 64'h700, 64'h700, 0, 2'd3);
    step("ovD",   ICALL, 64'h700, 64'hD, 0, 64'h700, 64'h700, 0, 2'd0);
    step("ovE",   ICALL, 64'h700, 64'hE, 0, 64'h700, 64'h700, 0, 2'd1);
    step("rt1",   IRET, 0, 64'h701, 0, 64'h700, 64'h700, 0, 2'd0);
    step("rt2",   IRET, 0, 64'h701, 0, 64'hE, 64'hE, 0, 2'd3);
    step("rt3",   IRET, 0, 64'h701, 0, 64'hD, 64'hD, 0, 2'd2);
    step("rt4",   IRET, 0, 64'h701, 0, 64'hC, 64'hC, 0, 2'd1);
    step("rt5",   IRET, 0, 64'h701, 0, 64'hB, 64'hB, 0, 2'd0);
    s_W_icode = IRET; s_W_valM = 64'hA; s_W_predPC = 64'hE; s_W_ptr = 0;
    step("rtfix", INOP, 0, 64'hB, 0, 64'hE, 64'hA, 1, 2'd0);
`endif
    s_rst_n = 1'b0;
    step("rstmid", INOP, 0, 64'h1, 0, 64'h0, 64'h0, 0, 0);
    s_rst_n = 1'b1;
    step("rel",    INOP, 0, 64'h1, 0, 64'h0, 64'h0, 0, 0);
    step("uflow",  IRET, 0, 64'h2, 0, 64'h1, 64'h1, 0, RAS ? 2'd3 : 2'd0);
    step("ufres",  INOP, 0, 64'h3, 0, RAS ? 64'h0 : 64'h2, RAS ? 64'h0 : 64'h2, 0,
         RAS ? 2'd3 : 2'd0);

    @(negedge clk);
    #1;
    chk("drain", "queue", 64'(q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
